// File: rtl/sum_acc_pkg.sv
// Shared types and defaults for the adder-sum window accumulator.
package sum_acc_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } acc_state_e;

  localparam int unsigned ADD_SUM_W  = 5;
  localparam int unsigned ACC_W_DEF  = 8;
  localparam int unsigned WINDOW_DEF = 4;

  // Largest unwrapped total a full window of in_w-bit samples can reach.
  function automatic int unsigned max_window_sum(input int unsigned window,
                                                 input int unsigned in_w);
    return window * ((32'd1 << in_w) - 32'd1);
  endfunction

endpackage

// File: rtl/sum_window_acc.sv
// Accumulates WINDOW adder sums and presents the wrapped total plus a sticky
// overflow flag on a valid/ready result port.
module sum_window_acc
  import sum_acc_pkg::*;
#(
  parameter int unsigned IN_W   = ADD_SUM_W,
  parameter int unsigned ACC_W  = ACC_W_DEF,
  parameter int unsigned WINDOW = WINDOW_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf,
  input  logic             out_ready
);

  localparam int unsigned CNT_W = $clog2(WINDOW);
  localparam int unsigned SUM_W = ACC_W + 1;

  if (ACC_W < IN_W) begin : g_bad_acc_w
    $error("sum_window_acc: ACC_W must be >= IN_W");
  end
  if (WINDOW < 2) begin : g_bad_window
    $error("sum_window_acc: WINDOW must be >= 2");
  end

  acc_state_e       state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             ovf;

  logic [SUM_W-1:0] add_full;
  logic             accept;
  logic             last;

  // Top bit of the widened add is the carry-out of the ACC_W-bit accumulate.
  assign add_full = {1'b0, acc} + SUM_W'(in_data);
  assign in_ready = (state == ACCUM);
  assign accept   = in_valid && in_ready;
  assign last     = (cnt == CNT_W'(WINDOW - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ACCUM;
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_ovf   <= 1'b0;
    end else if (clear) begin
      // Drops any partial window and any pending result; out_sum keeps its value.
      state     <= ACCUM;
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            if (last) begin
              out_sum   <= add_full[ACC_W-1:0];
              out_ovf   <= ovf | add_full[ACC_W];
              out_valid <= 1'b1;
              acc       <= '0;
              cnt       <= '0;
              ovf       <= 1'b0;
              state     <= HOLD;
            end else begin
              acc <= add_full[ACC_W-1:0];
              ovf <= ovf | add_full[ACC_W];
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_sum_window_acc.sv
// Scoreboard bench for sum_window_acc: an 8-bit accumulator instance and a
// 6-bit one for wrap/overflow behaviour.
module tb_sum_window_acc;
  import sum_acc_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       a_clr, a_v, a_rdy, a_ov, a_ovf, a_ordy;
  logic [4:0] a_d;
  logic [7:0] a_sum;
  logic       b_clr, b_v, b_rdy, b_ov, b_ovf, b_ordy;
  logic [4:0] b_d;
  logic [5:0] b_sum;

  sum_window_acc #(.IN_W(ADD_SUM_W), .ACC_W(8), .WINDOW(4)) dut_a (
    .clk(clk), .rst(rst), .clear(a_clr), .in_valid(a_v), .in_data(a_d),
    .in_ready(a_rdy), .out_valid(a_ov), .out_sum(a_sum), .out_ovf(a_ovf),
    .out_ready(a_ordy)
  );

  sum_window_acc #(.IN_W(5), .ACC_W(6), .WINDOW(4)) dut_b (
    .clk(clk), .rst(rst), .clear(b_clr), .in_valid(b_v), .in_data(b_d),
    .in_ready(b_rdy), .out_valid(b_ov), .out_sum(b_sum), .out_ovf(b_ovf),
    .out_ready(b_ordy)
  );

  typedef struct packed {
    logic [7:0] sum;
    logic       ovf;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   hs_a  = 0;
  int   hs_b  = 0;

  task automatic check(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic rdy(input int ch);
    return (ch == 0) ? a_rdy : b_rdy;
  endfunction

  function automatic logic ov(input int ch);
    return (ch == 0) ? a_ov : b_ov;
  endfunction

  task automatic setv(input int ch, input logic v, input int d);
    if (ch == 0) begin
      a_v = v;
      a_d = 5'(d);
    end else begin
      b_v = v;
      b_d = 5'(d);
    end
  endtask

  task automatic expect_res(input int ch, input int sum, input logic o);
    exp_t e;
    e.sum = 8'(sum);
    e.ovf = o;
    if (ch == 0) q_a.push_back(e);
    else         q_b.push_back(e);
  endtask

  // Offer one beat and hold it until accepted.
  task automatic push(input int ch, input int d);
    int n = 0;
    setv(ch, 1'b1, d);
    while (!rdy(ch) && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) check("push_timeout", 0, 1);
    step();
    setv(ch, 1'b0, 0);
  endtask

  task automatic wait_result(input int ch);
    int n = 0;
    while (!ov(ch) && n < 20) begin
      step();
      n++;
    end
    if (n >= 20) check("result_timeout", 0, 1);
    n = 0;
    while (ov(ch) && n < 20) begin
      step();
      n++;
    end
    if (n >= 20) check("consume_timeout", 0, 1);
  endtask

  task automatic window(input int ch, input int d0, input int d1, input int d2,
                        input int d3, input int esum, input logic eovf);
    expect_res(ch, esum, eovf);
    push(ch, d0);
    push(ch, d1);
    push(ch, d2);
    push(ch, d3);
    wait_result(ch);
  endtask

  // Monitor: while a result is presented it must match the queue head.
  task automatic mon(input int ch, input logic ordy, input logic [7:0] s, input logic o);
    exp_t e;
    if ((ch == 0) ? (q_a.size() == 0) : (q_b.size() == 0)) begin
      n_cmp++;
      n_err++;
      $display("FAIL unexpected_result ch%0d: got sum %0d, expected no result", ch, s);
      return;
    end
    e = (ch == 0) ? q_a[0] : q_b[0];
    check(ordy ? "result_sum" : "held_sum", int'(s), int'(e.sum));
    check(ordy ? "result_ovf" : "held_ovf", int'(o), int'(e.ovf));
    if (ordy) begin
      if (ch == 0) begin
        void'(q_a.pop_front());
        hs_a++;
      end else begin
        void'(q_b.pop_front());
        hs_b++;
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (a_ov) mon(0, a_ordy, a_sum, a_ovf);
      if (b_ov) mon(1, b_ordy, 8'(b_sum), b_ovf);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    a_clr = 1'b0; a_v = 1'b0; a_d = '0; a_ordy = 1'b1;
    b_clr = 1'b0; b_v = 1'b0; b_d = '0; b_ordy = 1'b1;
    repeat (3) step();
    rst = 1'b0;

    check("rst_a_in_ready", int'(a_rdy), 1);
    check("rst_a_out_valid", int'(a_ov), 0);
    check("rst_a_out_sum", int'(a_sum), 0);
    check("rst_a_out_ovf", int'(a_ovf), 0);
    check("rst_b_in_ready", int'(b_rdy), 1);
    check("rst_b_out_valid", int'(b_ov), 0);
    check("rst_b_out_sum", int'(b_sum), 0);
    check("rst_b_out_ovf", int'(b_ovf), 0);

    // Back-to-back window; result one cycle after the 4th accept.
    expect_res(0, 64, 1'b0);
    push(0, 30);
    push(0, 31);
    push(0, 1);
    push(0, 2);
    check("lat_out_valid", int'(a_ov), 1);
    check("lat_in_ready_low", int'(a_rdy), 0);
    step();
    check("lat_in_ready_back", int'(a_rdy), 1);
    check("lat_out_valid_drop", int'(a_ov), 0);

    // Backpressure with upstream holding the next beat.
    a_ordy = 1'b0;
    expect_res(0, 20, 1'b0);
    push(0, 5);
    push(0, 5);
    push(0, 5);
    push(0, 5);
    check("bp_out_valid_rise", int'(a_ov), 1);
    setv(0, 1'b1, 1);
    for (int i = 0; i < 6; i++) begin
      step();
      check("bp_in_ready", int'(a_rdy), 0);
      check("bp_out_valid", int'(a_ov), 1);
    end
    expect_res(0, 4, 1'b0);
    a_ordy = 1'b1;
    push(0, 1);
    push(0, 1);
    push(0, 1);
    push(0, 1);
    wait_result(0);

    // Wrap in the 6-bit instance, then overflow flag must not leak.
    window(1, 31, 31, 31, 31, 60, 1'b1);
    window(1, 1, 2, 3, 4, 10, 1'b0);

    // Gaps in the valid stream.
    expect_res(0, 34, 1'b0);
    setv(0, 1'b1, 7);  step();
    setv(0, 1'b0, 19); step();
    setv(0, 1'b0, 23); step();
    setv(0, 1'b1, 8);  step();
    setv(0, 1'b0, 21); step();
    setv(0, 1'b1, 9);  step();
    setv(0, 1'b1, 10); step();
    setv(0, 1'b0, 0);
    wait_result(0);

    // clear mid-window drops the partial sum and a same-cycle beat.
    push(0, 3);
    push(0, 4);
    setv(0, 1'b1, 9);
    a_clr = 1'b1;
    step();
    a_clr = 1'b0;
    setv(0, 1'b0, 0);
    window(0, 1, 1, 1, 1, 4, 1'b0);

    // clear in HOLD discards the pending result.
    a_ordy = 1'b0;
    expect_res(0, 8, 1'b0);
    push(0, 2);
    push(0, 2);
    push(0, 2);
    push(0, 2);
    step();
    step();
    a_clr = 1'b1;
    step();
    a_clr = 1'b0;
    check("clr_hold_out_valid", int'(a_ov), 0);
    check("clr_hold_in_ready", int'(a_rdy), 1);
    check("clr_hold_out_sum_kept", int'(a_sum), 8);
    void'(q_a.pop_front());
    a_ordy = 1'b1;

    // rst mid-window.
    push(0, 1);
    push(0, 1);
    push(0, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_mid_out_valid", int'(a_ov), 0);
    check("rst_mid_in_ready", int'(a_rdy), 1);

    // rst in HOLD.
    a_ordy = 1'b0;
    expect_res(0, 20, 1'b0);
    push(0, 5);
    push(0, 5);
    push(0, 5);
    push(0, 5);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    void'(q_a.pop_front());
    check("rst_hold_out_valid", int'(a_ov), 0);
    check("rst_hold_in_ready", int'(a_rdy), 1);
    check("rst_hold_out_sum", int'(a_sum), 0);
    a_ordy = 1'b1;
    window(0, 2, 2, 2, 2, 8, 1'b0);

    repeat (2) step();
    check("handshakes_a", hs_a, 6);
    check("handshakes_b", hs_b, 2);
    check("pending_a", q_a.size(), 0);
    check("pending_b", q_b.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
